step_sequencer: RTL and testbench



---
 rtl/step_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_step_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: step/direction pulse generator for a stepper driver.
//
// Accepts one move command at a time (step count, direction, period) and
// emits exactly that many step pulses. The direction output is updated on
// accept and held for DIR_SETUP cycles before the first step rises. Every
// step is high for PULSE_CYC cycles. Rising edges are eff_period apart,
// where eff_period = max(cmd_period, PULSE_CYC+1).
//
// Optional feature macro: STEP_RAMP_EN
//   When defined, the step interval follows a trapezoidal profile. It
//   starts at max(START_PER, eff_period) and falls by RAMP_DEC per step
//   down to eff_period. It rises again by RAMP_DEC per step near the end
//   of the move, capped at the start interval.
//   When undefined, the interval is constant, and START_PER and RAMP_DEC
//   are unused.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = IDLE & ~rst)
//   cmd_steps, cmd_dir,      move parameters, latched on accept
//   cmd_period
//   abort                    stop at next safe point (never a runt pulse)
//   step, dir                driver pins
//   busy                     move in progress
//   done, aborted            one-cycle end-of-move pulse, plus abort flag
//   steps_left               steps not yet issued
module step_sequencer #(
    parameter int CNT_W     = 24,
    parameter int PER_W     = 16,
    parameter int PULSE_CYC = 8,
    parameter int DIR_SETUP = 4,
    parameter int START_PER = 4000,
    parameter int RAMP_DEC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE_HI,
        S_PULSE_LO,
        S_DONE
    } state_t;

    // The shortest legal period leaves one low cycle after the high time.
    localparam logic [PER_W-1:0] MIN_PER   = PER_W'(PULSE_CYC + 1);
    localparam logic [PER_W-1:0] SETUP_LD  = PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] HI_LD     = PER_W'(PULSE_CYC - 1);

    state_t           state_reg;
    logic [PER_W-1:0] cnt_reg;        // cycles remaining in current phase, minus one
    logic [PER_W-1:0] per_reg;        // interval of the pulse in flight
    logic             abort_pend_reg; // abort seen during the high time
    logic             step_reg;
    logic             dir_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             aborted_reg;
    logic [CNT_W-1:0] steps_left_reg;

    logic [PER_W-1:0] eff_period;
    logic [PER_W-1:0] hi_per;         // interval to use for the pulse about to rise

    assign eff_period = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;

`ifdef STEP_RAMP_EN
    localparam logic [PER_W:0] START_X = (PER_W + 1)'(START_PER);
    localparam logic [PER_W:0] DEC_X   = (PER_W + 1)'(RAMP_DEC);

    logic [PER_W-1:0] floor_reg;      // eff_period of the current move
    logic [CNT_W-1:0] accel_cnt_reg;  // steps taken above the floor while accelerating
    logic             decel_reg;      // deceleration has begun
    logic             ramp_decel;
    logic [PER_W:0]   ramp_top;
    logic [PER_W:0]   ramp_sum;

    always_comb begin
        ramp_top   = (START_X > {1'b0, floor_reg}) ? START_X : {1'b0, floor_reg};
        ramp_sum   = {1'b0, per_reg} + DEC_X;
        ramp_decel = 1'b0;
        hi_per     = per_reg;
        if (state_reg == S_SETUP) begin
            hi_per = ramp_top[PER_W-1:0];
        end else begin
            // steps_left is still the pre-decrement count here
            ramp_decel = decel_reg || (steps_left_reg <= accel_cnt_reg);
            if (ramp_decel) begin
                hi_per = (ramp_sum > ramp_top) ? ramp_top[PER_W-1:0] : ramp_sum[PER_W-1:0];
            end else if ({1'b0, per_reg} > ({1'b0, floor_reg} + DEC_X)) begin
                hi_per = per_reg - DEC_X[PER_W-1:0];
            end else begin
                hi_per = floor_reg;
            end
        end
    end
`else
    always_comb begin
        hi_per = per_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            per_reg        <= '0;
            abort_pend_reg <= 1'b0;
            step_reg       <= 1'b0;
            dir_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            steps_left_reg <= '0;
`ifdef STEP_RAMP_EN
            floor_reg      <= '0;
            accel_cnt_reg  <= '0;
            decel_reg      <= 1'b0;
`endif
        end else begin
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // cmd_ready is 1 here because rst is low
                    if (cmd_valid) begin
                        dir_reg        <= cmd_dir;
                        steps_left_reg <= cmd_steps;
                        per_reg        <= eff_period;
                        abort_pend_reg <= 1'b0;
`ifdef STEP_RAMP_EN
                        floor_reg      <= eff_period;
                        accel_cnt_reg  <= '0;
                        decel_reg      <= 1'b0;
`endif
                        if (cmd_steps == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_SETUP;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= SETUP_LD;
                        end
                    end
                end

                S_SETUP, S_PULSE_LO: begin
                    if (abort) begin
                        state_reg   <= S_DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        aborted_reg <= 1'b1;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (state_reg == S_PULSE_LO && steps_left_reg == '0) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        // Rise of the next step
                        state_reg      <= S_PULSE_HI;
                        step_reg       <= 1'b1;
                        cnt_reg        <= HI_LD;
                        per_reg        <= hi_per;
                        steps_left_reg <= steps_left_reg - 1'b1;
                        abort_pend_reg <= 1'b0;
`ifdef STEP_RAMP_EN
                        decel_reg <= ramp_decel;
                        if (!ramp_decel && hi_per > floor_reg) begin
                            accel_cnt_reg <= accel_cnt_reg + 1'b1;
                        end
`endif
                    end
                end

                S_PULSE_HI: begin
                    // Abort is remembered so the high time always completes
                    if (cnt_reg != '0) begin
                        cnt_reg        <= cnt_reg - 1'b1;
                        abort_pend_reg <= abort_pend_reg | abort;
                    end else begin
                        step_reg <= 1'b0;
                        if (abort_pend_reg || abort) begin
                            state_reg   <= S_DONE;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            aborted_reg <= 1'b1;
                        end else begin
                            state_reg <= S_PULSE_LO;
                            cnt_reg   <= per_reg - MIN_PER;
                        end
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    step_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_reg == S_IDLE) && !rst;
    assign step       = step_reg;
    assign dir        = dir_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign steps_left = steps_left_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer (default build, constant cadence).
// Every cycle of every move is compared against a waveform model computed
// arithmetically from the move parameters. Table rows also carry
// hand-derived end-of-move results.
module tb_step_sequencer;

    localparam int CNT_W = 24;
    localparam int PER_W = 16;
    localparam int PC    = 8;
    localparam int DS    = 4;
    localparam int VW    = CNT_W + 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic [PER_W-1:0] cmd_period = '0;
    logic             abort = 1'b0;
    logic             step, dir, busy, done, aborted;
    logic [CNT_W-1:0] steps_left;

    int vectors = 0;
    int miscompares = 0;

    step_sequencer #(
        .CNT_W(CNT_W), .PER_W(PER_W), .PULSE_CYC(PC), .DIR_SETUP(DS),
        .START_PER(4000), .RAMP_DEC(16)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
        .abort(abort), .step(step), .dir(dir), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int steps;
        bit dir;
        int period;
        int abort_t;    // cycle offset from accept; -1 = none
        int exp_done_t; // expected done cycle offset
        bit exp_ab;
        int exp_left;
    } vec_t;

    function automatic logic [VW-1:0] pack_out();
        return {step, dir, busy, done, aborted, cmd_ready, steps_left};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got step/dir/busy/done/ab/rdy=%b left=%0d, want %b left=%0d",
                     name, act[VW-1:CNT_W], act[CNT_W-1:0], exp[VW-1:CNT_W], exp[CNT_W-1:0]);
        end
    endtask

    // End-of-move outcome from the move parameters.
    function automatic void plan(input int n, input int eff, input int ta,
                                 output int done_t, output bit ab, output int issued);
        int k, ph;
        done_t = (n == 0) ? 1 : 1 + DS + n * eff;
        ab = 0;
        issued = n;
        if (n > 0 && ta >= 1 && ta < done_t) begin
            ab = 1;
            if (ta <= DS) begin
                done_t = ta + 1;
                issued = 0;
            end else begin
                k  = (ta - 1 - DS) / eff;
                ph = (ta - 1 - DS) % eff;
                issued = k + 1;
                done_t = (ph < PC) ? (1 + DS + k * eff + PC) : ta + 1;
            end
        end
    endfunction

    function automatic logic [VW-1:0] expect_at(input int t, input int n, input bit d,
                                                input int eff, input int done_t,
                                                input bit ab, input int issued);
        int rises = 0;
        bit st = 0;
        int r;
        for (int k = 0; k < issued; k++) begin
            r = 1 + DS + k * eff;
            if (r <= t) rises++;
            if (t >= r && t < r + PC && t < done_t) st = 1;
        end
        return {st, d, (n > 0 && t < done_t), (t == done_t), (t == done_t && ab),
                (t > done_t), CNT_W'(n - rises)};
    endfunction

    task automatic run_cmd(input int n, input bit d, input int per, input int ta,
                           output int obs_done, output bit obs_ab, output int obs_left);
        int w = 0;
        int eff, done_t, issued;
        bit ab;
        obs_done = -1; obs_ab = 0; obs_left = -1;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait: cmd_ready=0 after %0d cycles, want 1", w);
            return;
        end
        eff = (per < PC + 1) ? PC + 1 : per;
        plan(n, eff, ta, done_t, ab, issued);
        cmd_valid  = 1'b1;
        cmd_steps  = CNT_W'(n);
        cmd_dir    = d;
        cmd_period = PER_W'(per);
        abort      = (ta == 0);
        for (int t = 1; t <= done_t + 1; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check($sformatf("n%0d_p%0d_t%0d", n, per, t), pack_out(),
                  expect_at(t, n, d, eff, done_t, ab, issued));
            if (done && obs_done < 0) begin
                obs_done = t;
                obs_ab   = aborted;
                obs_left = int'(steps_left);
            end
            abort = (t == ta);
        end
        abort = 1'b0;
        $display("cmd steps=%0d dir=%0d period=%0d abort_t=%0d -> done@%0d aborted=%0d left=%0d",
                 n, d, per, ta, obs_done, obs_ab, obs_left);
    endtask

    initial begin
        vec_t tbl[9];
        int od, ol;
        bit oab;
        int n, per, ta;
        bit d;

        tbl[0] = '{3,   1, 20, -1, 65, 0, 0};   // nominal move
        tbl[1] = '{2,   0, 3,  -1, 23, 0, 0};   // period clamped to 9
        tbl[2] = '{0,   1, 10, -1, 1,  0, 0};   // zero steps
        tbl[3] = '{100, 1, 20, 87, 93, 1, 95};  // abort in 3rd high cycle of step 5
        tbl[4] = '{5,   0, 12, 2,  3,  1, 5};   // abort during setup
        tbl[5] = '{4,   1, 15, 30, 31, 1, 2};   // abort in low phase of step 2
        tbl[6] = '{3,   0, 9,  0,  32, 0, 0};   // abort with accept is ignored
        tbl[7] = '{1,   1, 9,  13, 14, 1, 0};   // abort in final low cycle
        tbl[8] = '{2,   0, 16, 37, 37, 0, 0};   // abort during DONE is ignored

        // Reset state
        repeat (2) @(negedge clk);
        check("reset", pack_out(), '0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_cmd(tbl[i].steps, tbl[i].dir, tbl[i].period, tbl[i].abort_t, od, oab, ol);
            check($sformatf("row%0d_end", i),
                  {6'b0, oab, CNT_W'(ol), CNT_W'(od)} >> CNT_W,
                  {6'b0, tbl[i].exp_ab, CNT_W'(tbl[i].exp_left), CNT_W'(tbl[i].exp_done_t)} >> CNT_W);
            check($sformatf("row%0d_done_t", i), VW'(od), VW'(tbl[i].exp_done_t));
        end

        // Reset in the low phase of step 2 (rise at 25, low 33..44)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_steps = CNT_W'(6); cmd_dir = 1'b1; cmd_period = PER_W'(20);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (37) @(negedge clk);
        check("pre_reset_lo", pack_out(), {1'b0, 1'b1, 1'b1, 3'b000, CNT_W'(4)});
        rst = 1'b1;
        @(negedge clk);
        check("in_reset", pack_out(), '0);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset", pack_out(), {5'b0, 1'b1, CNT_W'(0)});
        $display("reset mid-move applied");

        // Randomized moves against the model
        for (int r = 0; r < 14; r++) begin
            n   = $urandom_range(0, 6);
            per = $urandom_range(0, 40);
            d   = 1'($urandom_range(0, 1));
            ta  = ($urandom_range(0, 1) == 1) ? -1
                  : $urandom_range(0, 1 + DS + n * ((per < PC + 1) ? PC + 1 : per) + 1);
            run_cmd(n, d, per, ta, od, oab, ol);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
